// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// Module   : fifo_arb_pkg
// Purpose  : Shared types, constants and the round-robin helper for the FIFO
//            write-port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  localparam int STAT_WIDTH = 16;
  localparam int c_MAX_REQ  = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Returns {found, index}: the first set bit of valid at or after (last+1) mod n.
  function automatic logic [4:0] rr_next(input logic [15:0] valid,
                                         input logic [3:0]  last,
                                         input int          n);
    logic [4:0] res;
    int         idx;
    res = '0;
    for (int k = 1; k <= c_MAX_REQ; k++) begin
      idx = (int'(last) + k) % n;
      if (k <= n && !res[4] && valid[idx[3:0]]) res = {1'b1, idx[3:0]};
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational rotate-priority picker; searches upward from the
//            slot after the last grant, wrapping at NUM_REQ.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [4:0] w_pick;

  assign w_pick = rr_next(16'(req), 4'(last), NUM_REQ);
  assign found  = w_pick[4];
  assign idx    = IDX_W'(w_pick[3:0]);

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Burst-locked round-robin arbiter sharing one FIFO write port.
//            Optional per-requester beat counters: FIFO_WR_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                          clk,
  input  logic                          rst_async_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*WIDTH-1:0]      req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [WIDTH-1:0]              fifo_din,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [NUM_REQ*STAT_WIDTH-1:0] stat_beats
);

  localparam int c_IDX_W = $clog2(NUM_REQ);
  localparam int c_CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e           r_state;
  logic [c_IDX_W-1:0]   r_grant_id;
  logic [c_IDX_W-1:0]   r_last_grant;
  logic [c_CNT_W-1:0]   r_beat_cnt;

  logic                 w_in_burst;
  logic                 w_xfer;
  logic                 w_release;
  logic                 w_found;
  logic [c_IDX_W-1:0]   w_pick_idx;
  logic [WIDTH-1:0]     w_lane [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign w_lane[i] = req_data[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .last  (r_last_grant),
    .found (w_found),
    .idx   (w_pick_idx)
  );

  // Outputs decode from the state register, so async reset silences them at once.
  assign w_in_burst = (r_state == BURST);
  assign w_xfer     = w_in_burst && req_valid[r_grant_id] && !fifo_full;
  assign w_release  = w_xfer && (req_last[r_grant_id] ||
                                 r_beat_cnt == c_CNT_W'(MAX_BURST - 1));

  assign fifo_wr_en = w_xfer;
  assign fifo_din   = w_lane[r_grant_id];
  assign grant_id   = r_grant_id;
  assign busy       = w_in_burst;

  always_comb begin
    req_ready = '0;
    if (w_in_burst) req_ready[r_grant_id] = !fifo_full;
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_last_grant <= c_IDX_W'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant_id   <= w_pick_idx;
            r_last_grant <= w_pick_idx;
            r_beat_cnt   <= '0;
            r_state      <= BURST;
          end
        end
        BURST: begin
          if (w_xfer) begin
            if (w_release) begin
              r_beat_cnt <= '0;
              r_state    <= IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [STAT_WIDTH-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
        r_cnt <= '0;
      end else if (w_xfer && r_grant_id == c_IDX_W'(i) && r_cnt != '1) begin
        r_cnt <= r_cnt + STAT_WIDTH'(1);
      end
    end
    assign stat_beats[i*STAT_WIDTH +: STAT_WIDTH] = r_cnt;
  end
`else
  assign stat_beats = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Self-checking bench: vector table, corner-case sequences and a
//            randomized run against a packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 16;

  logic             clk = 1'b0;
  logic             rst_async_n;
  logic [N-1:0]     req_valid, req_last, req_ready;
  logic [N*W-1:0]   req_data;
  logic [W-1:0]     fifo_din;
  logic             fifo_wr_en, fifo_full;
  logic [1:0]       grant_id;
  logic             busy;
  logic [N*16-1:0]  stat_beats;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_din    (fifo_din),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_full   (fifo_full),
    .grant_id    (grant_id),
    .busy        (busy),
    .stat_beats  (stat_beats)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: owner of the port (-1 = none) and beats moved in this grant.
  int m_owner, m_last, m_gid, m_beats;
  int m_stat [N];
  bit m_wr;
  int wr_seen;

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_gid = 0; m_beats = 0;
    foreach (m_stat[i]) m_stat[i] = 0;
  endtask

  task automatic check_model();
    logic [N-1:0]    e_rdy;
    logic [N*16-1:0] e_st;
    e_rdy = '0;
    m_wr  = 1'b0;
    if (m_owner >= 0 && !fifo_full) begin
      e_rdy[m_owner] = 1'b1;
      m_wr = req_valid[m_owner];
    end
    e_st = '0;
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) e_st[i*16 +: 16] = 16'(m_stat[i]);
`endif
    chk("model_busy",  busy,       m_owner >= 0);
    chk("model_grant", grant_id,   m_gid);
    chk("model_ready", req_ready,  e_rdy);
    chk("model_wr_en", fifo_wr_en, m_wr);
    chk("model_din",   fifo_din,   req_data[m_gid*W +: W]);
    chk("model_stats", stat_beats, e_st);
    if (fifo_wr_en) wr_seen++;
  endtask

  task automatic advance();
    @(posedge clk);
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (req_valid[c]) begin
          m_owner = c; m_gid = c; m_last = c; m_beats = 0;
          break;
        end
      end
    end else if (m_wr) begin
      m_beats++;
      if (m_stat[m_owner] < 65535) m_stat[m_owner]++;
      if (req_last[m_owner] || m_beats == MB) m_owner = -1;
    end
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    advance();
  endtask

  task automatic do_reset();
    rst_async_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_async_n = 1'b1;
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] v;
    logic [N-1:0] l;
    bit           f;
    bit           e_busy;
    int           e_gid;
    bit           e_wr;
    logic [N-1:0] e_rdy;
  } vec_t;

  function automatic vec_t mk(bit rst, logic [N-1:0] v, logic [N-1:0] l, bit f,
                              bit e_busy, int e_gid, bit e_wr, logic [N-1:0] e_rdy);
    vec_t r;
    r.rst = rst; r.v = v; r.l = l; r.f = f;
    r.e_busy = e_busy; r.e_gid = e_gid; r.e_wr = e_wr; r.e_rdy = e_rdy;
    return r;
  endfunction

  vec_t tbl [$];

  initial begin
    rst_async_n = 1'b0;
    req_valid = '0; req_last = '0; fifo_full = 1'b0;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    wr_seen   = 0;
    model_reset();

    // Single requester, 3-beat packet, then all four with 1-beat packets.
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 0, 1, 0, 1, 4'b0001));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 0, 1, 0, 1, 4'b0001));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 0, 1, 0, 1, 4'b0001));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, 0, 1, 4'b0001));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 0, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, 1, 1, 4'b0010));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 1, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, 2, 1, 4'b0100));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 2, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, 3, 1, 4'b1000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 3, 0, 4'b0000));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, 0, 1, 4'b0001));

    #2;
    @(negedge clk);
    chk("reset_outputs", {busy, fifo_wr_en, req_ready, grant_id, stat_beats},
        {1'b0, 1'b0, 4'b0000, 2'd0, 64'd0});

    foreach (tbl[r]) begin
      if (tbl[r].rst) do_reset();
      req_valid = tbl[r].v; req_last = tbl[r].l; fifo_full = tbl[r].f;
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", r),  busy,       tbl[r].e_busy);
      chk($sformatf("tbl%0d_grant", r), grant_id,   tbl[r].e_gid);
      chk($sformatf("tbl%0d_wr", r),    fifo_wr_en, tbl[r].e_wr);
      chk($sformatf("tbl%0d_ready", r), req_ready,  tbl[r].e_rdy);
      chk($sformatf("tbl%0d_din", r),   fifo_din,   8'hA0 + 8'(tbl[r].e_gid));
      check_model();
      advance();
    end

    // Requester 2 streams without last: forced off after MAX_BURST beats.
    do_reset();
    req_valid = 4'b1100; req_last = 4'b1000;
    step();
    for (int i = 0; i < MB; i++) begin
      @(negedge clk);
      chk($sformatf("s3_beat%0d", i), {busy, grant_id, fifo_wr_en}, {1'b1, 2'd2, 1'b1});
      check_model();
      advance();
    end
    @(negedge clk);
    chk("s3_release", busy, 1'b0);
    check_model(); advance();
    @(negedge clk);
    chk("s3_next", {busy, grant_id}, {1'b1, 2'd3});
    check_model(); advance();
    step();
    @(negedge clk);
    chk("s3_back", {busy, grant_id}, {1'b1, 2'd2});
    check_model(); advance();

    // FIFO full for 5 cycles in the middle of a burst.
    do_reset();
    req_valid = 4'b0001; req_last = 4'b0000;
    step();
    wr_seen = 0;
    req_data[7:0] = 8'h11; step();
    req_data[7:0] = 8'h22; step();
    req_data[7:0] = 8'h33;
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("s4_full%0d", i), {busy, fifo_wr_en, req_ready}, {1'b1, 1'b0, 4'b0000});
      check_model();
      advance();
    end
    fifo_full = 1'b0;
    step();
    req_data[7:0] = 8'h44; req_last = 4'b0001; step();
    req_last = 4'b0000; req_valid = 4'b0000;
    @(negedge clk);
    chk("s4_beats", wr_seen, 4);
    chk("s4_idle", busy, 1'b0);
    check_model(); advance();

    // Asynchronous reset after two beats of a burst.
    do_reset();
    req_valid = 4'b0010; req_last = 4'b0000;
    step(); step(); step();
    #2;
    rst_async_n = 1'b0;
    #1;
    chk("s5_async_reset", {busy, fifo_wr_en, req_ready}, {1'b1 == 1'b0, 1'b0, 4'b0000});
    model_reset();
    @(posedge clk); #1;
    rst_async_n = 1'b1;
    req_valid = 4'b1111; req_last = 4'b1111;
    step();
    @(negedge clk);
    chk("s5_first_grant", {busy, grant_id}, {1'b1, 2'd0});
    check_model(); advance();

    // Eight 1-beat grants: two beats per requester.
    do_reset();
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < 16; i++) step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
`ifdef FIFO_WR_ARB_STATS_EN
      chk($sformatf("s6_stat%0d", i), stat_beats[i*16 +: 16], 16'd2);
`else
      chk($sformatf("s6_stat%0d", i), stat_beats[i*16 +: 16], 16'd0);
`endif
    end
    check_model(); advance();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req_valid = 4'($urandom);
      req_last  = 4'($urandom) & 4'($urandom);
      fifo_full = ($urandom_range(0, 4) == 0);
      req_data  = 32'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
